// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined slave backed by a word-addressed memory; every request terminates in order LATENCY cycles after acceptance.
// Optional stall injection from an 8-bit LFSR is built when WB_MEM_SLAVE_STALL_INJECT_EN is defined.
module wb_mem_slave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic                    wb_stall_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o
);

    localparam int SEL_W  = DATA_WIDTH / 8;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [LATENCY-1:0]    pipe_valid;
    logic                  pipe_we  [LATENCY];
    logic                  pipe_oor [LATENCY];
    logic [MEM_AW-1:0]     pipe_idx [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_dat [LATENCY];
    logic [SEL_W-1:0]      pipe_sel [LATENCY];

    logic [CNT_W-1:0] outstanding;
    logic             inject;
    logic             accept;
    logic             req_oor;
    logic             fin_valid;
    logic             fin_ok;
    logic             fin_write;
    logic             term;
    logic             unused_adr_lsbs;

    // Handshake: a request is taken at a rising edge when cyc & stb are high and
    // stall_o was low during the preceding cycle; the master holds stb until then.
    assign accept    = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign req_oor   = |wb_adr_i[ADDR_WIDTH-1:MEM_AW+2];
    assign fin_valid = pipe_valid[LATENCY-1] & wb_cyc_i;
    assign fin_ok    = fin_valid & ~pipe_oor[LATENCY-1];
    assign fin_write = fin_ok & pipe_we[LATENCY-1];
    assign term      = wb_ack_o | wb_err_o;
    assign unused_adr_lsbs = &{1'b0, wb_adr_i[1:0]};

    assign wb_stall_o = (outstanding == CNT_W'(MAX_OUTSTANDING)) | inject;

    // Dropping cyc kills every in-flight entry on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] & wb_cyc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_we[0]  <= wb_we_i;
        pipe_oor[0] <= req_oor;
        pipe_idx[0] <= wb_adr_i[MEM_AW+1:2];
        pipe_dat[0] <= wb_dat_i;
        pipe_sel[0] <= wb_sel_i;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_we[i]  <= pipe_we[i-1];
            pipe_oor[i] <= pipe_oor[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
            pipe_sel[i] <= pipe_sel[i-1];
        end
    end

    // Writes land on the termination edge, so a later read in the pipe sees them.
    always_ff @(posedge clk) begin
        if (fin_write) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (pipe_sel[LATENCY-1][b]) begin
                    mem[pipe_idx[LATENCY-1]][8*b +: 8] <= pipe_dat[LATENCY-1][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= fin_ok;
            wb_err_o <= fin_valid & pipe_oor[LATENCY-1];
            wb_dat_o <= (fin_ok & ~pipe_we[LATENCY-1]) ? mem[pipe_idx[LATENCY-1]] : '0;
        end
    end

    // A request stays counted until its ack/err cycle has completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (!wb_cyc_i) begin
            outstanding <= '0;
        end else if (accept && !term) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && term) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

`ifdef WB_MEM_SLAVE_STALL_INJECT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'h5A;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign inject = (lfsr[1:0] == 2'b00);
`else
    assign inject = 1'b0;
`endif

endmodule
